bin_to_bcd: RTL

BIN_TO_BCD -- requirements
Module: bin_to_bcd

---
 rtl/bin_to_bcd_if.sv | 30 +++
 rtl/bin_to_bcd.sv | 119 +++++++++++
 2 files changed

// File: rtl/bin_to_bcd_if.sv
// ============================================================================
// bin_to_bcd_if : operand/result handshake bundle for the binary-to-BCD block
// Rev 1.0
// ============================================================================
`default_nettype none

interface bin_to_bcd_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic [DIGITS-1:0]     out_blank;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_bcd, out_blank
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_bcd, out_blank
  );
endinterface

`default_nettype wire

// File: rtl/bin_to_bcd.sv
// ============================================================================
// bin_to_bcd : sequential double-dabble binary-to-BCD converter with
//              leading-zero blanking flags. Rev 1.0
// ============================================================================
`default_nettype none

module bin_to_bcd #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  wire logic     clk,
  input  wire logic     rst,
  bin_to_bcd_if.slave   bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {DIGITS{1'b1}} << 1;

  function automatic bit digits_sufficient(input int bin_w, input int digits);
    logic [127:0] pow10;
    pow10 = 128'd1;
    for (int i = 0; i < digits; i++) pow10 = pow10 * 128'd10;
    return pow10 > ((128'd1 << bin_w) - 128'd1);
  endfunction

  if (!digits_sufficient(BIN_W, DIGITS)) begin : g_digit_check
    $error("bin_to_bcd: DIGITS too small to represent 2^BIN_W-1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                r_state;
  logic [BIN_W-1:0]      r_shift;
  logic [4*DIGITS-1:0]   r_work;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [DIGITS-1:0]     r_blank;

  logic [4*DIGITS-1:0]   w_adj;
  logic [4*DIGITS-1:0]   w_next;
  logic [DIGITS-1:0]     w_zero;
  logic [DIGITS-1:0]     w_blank;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign w_adj[4*i +: 4] = (r_work[4*i +: 4] >= 4'd5) ? r_work[4*i +: 4] + 4'd3
                                                        : r_work[4*i +: 4];
    assign w_zero[i] = (w_next[4*i +: 4] == 4'd0);
  end

  // Top adjusted bit falls off the shift; it is always zero for a legal DIGITS.
  assign w_next = (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_shift[BIN_W-1]};

  assign w_blank[0] = 1'b0;
  for (genvar i = 1; i < DIGITS; i++) begin : g_blank
    assign w_blank[i] = &w_zero[DIGITS-1:i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_work      <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_bcd       <= '0;
      r_blank     <= BLANK_RST;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_shift    <= bus.in_data;
            r_work     <= '0;
            r_cnt      <= CNT_W'(BIN_W);
            r_in_ready <= 1'b0;
            r_state    <= CONVERT;
          end
        end
        CONVERT: begin
          r_work  <= w_next;
          r_shift <= r_shift << 1;
          r_cnt   <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_bcd       <= w_next;
            r_blank     <= w_blank;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_bcd   = r_bcd;
  assign bus.out_blank = r_blank;

endmodule

`default_nettype wire
